echo_delay_ctrl: RTL



---
 rtl/audio_fx_pkg.sv | 11 +
 rtl/sat_mac.sv | 23 ++
 rtl/echo_delay_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/audio_fx_pkg.sv
// audio_fx_pkg: shared state encoding, default sample width and saturation helper for effect stages
package audio_fx_pkg;
    localparam int DEFAULT_DATA_WIDTH = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, MIX} fx_state_t;
    function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi, lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction
endpackage

// File: rtl/sat_mac.sv
// sat_mac: y = sat(x + floor(d * gain / 2^GW)), signed samples with unsigned Q0.GW gain
module sat_mac
    import audio_fx_pkg::*;
#(
    parameter int DW = DEFAULT_DATA_WIDTH,
    parameter int GW = 8
) (
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] d,
    input  logic        [GW-1:0] gain,
    output logic signed [DW-1:0] y
);
    localparam int PW = DW + GW + 1;
    localparam int SW = DW + 1;
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] sum;
    always_comb begin
        prod = PW'(d) * PW'($signed({1'b0, gain}));
        // the scaled wet term always fits in DW bits since gain < 1.0
        sum = SW'(x) + SW'(prod >>> GW);
        y = DW'(sat(32'(sum), DW));
    end
endmodule

// File: rtl/echo_delay_ctrl.sv
// echo_delay_ctrl: feed-forward echo around an external sync FIFO; one sample in flight at a time
module echo_delay_ctrl
    import audio_fx_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH      = 12,
    parameter int GAIN_WIDTH      = 8,
    parameter int FIFO_RD_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic                         sample_in_valid,
    input  logic        [ADDR_WIDTH-1:0] delay,
    input  logic        [GAIN_WIDTH-1:0] gain,
    input  logic                         bypass,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         sample_out_valid,
    output logic                         overrun,
    output logic                         fifo_wr_en,
    output logic signed [DATA_WIDTH-1:0] fifo_data_in,
    output logic                         fifo_rd_en,
    input  logic signed [DATA_WIDTH-1:0] fifo_data_out,
    input  logic        [ADDR_WIDTH-1:0] fifo_fill,
    input  logic                         fifo_full
);
    localparam int CW = $clog2(FIFO_RD_LATENCY + 1);
    fx_state_t state, state_next;
    logic signed [DATA_WIDTH-1:0] x, d, mix;
    logic [ADDR_WIDTH-1:0] delay_q;
    logic [CW-1:0] cnt;
    logic primed_now;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    // fifo strobes are gated by reset so every output reads 0 while reset is held
    always_comb begin
        state_next = state == IDLE  ? (sample_in_valid ? ISSUE : IDLE) :
                     state == ISSUE ? WAIT :
                     state == WAIT  ? (cnt == CW'(1) ? MIX : WAIT) : IDLE;
        fifo_wr_en = state == ISSUE && !fifo_full && !reset;
        fifo_rd_en = state == ISSUE && primed_now && !reset;
        fifo_data_in = fifo_wr_en ? x : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            delay_q <= delay;
            x <= '0;
            d <= '0;
            cnt <= '0;
            primed_now <= 1'b0;
            sample_out <= '0;
            sample_out_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            sample_out_valid <= state == MIX;
            if (sample_in_valid && state != IDLE) overrun <= 1'b1;
            // the FIFO holds exactly delay_q samples once primed, so its head is x[n-delay_q]
            if (state == IDLE && sample_in_valid) begin
                x <= sample_in;
                primed_now <= fifo_fill == delay_q;
            end
            if (state == ISSUE) cnt <= CW'(FIFO_RD_LATENCY);
            if (state == WAIT) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) d <= primed_now ? fifo_data_out : '0;
            end
            if (state == MIX) sample_out <= bypass ? x : mix;
        end
    end

    sat_mac #(.DW(DATA_WIDTH), .GW(GAIN_WIDTH)) mac (
        .x(x),
        .d(d),
        .gain(gain),
        .y(mix)
    );
endmodule
